// File: rtl/axi4lite_master.sv
// AXI4-Lite initiator: turns single-beat valid/ready commands into AXI4-Lite write or read
// transactions, one at a time, and returns the result with a hang-detection timeout.
module axi4lite_master #(
  parameter int ADDR_WIDTH     = 9,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    m_axi_aclk,
  input  logic                    m_axi_areset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_write,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  output logic                    rsp_timeout,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int CNT_WIDTH  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_AW_W = 3'd1,
    WR_B    = 3'd2,
    RD_AR   = 3'd3,
    RD_R    = 3'd4,
    RSP     = 3'd5
  } state_t;

  state_t                  state_r, state_s;
  logic [CNT_WIDTH-1:0]    cnt_r, cnt_s;
  logic                    cmd_ready_r, cmd_ready_s;
  logic                    awvalid_r, awvalid_s;
  logic                    wvalid_r, wvalid_s;
  logic                    bready_r, bready_s;
  logic                    arvalid_r, arvalid_s;
  logic                    rready_r, rready_s;
  logic                    rsp_valid_r, rsp_valid_s;
  logic                    rsp_write_r, rsp_write_s;
  logic [DATA_WIDTH-1:0]   rsp_rdata_r, rsp_rdata_s;
  logic [1:0]              rsp_resp_r, rsp_resp_s;
  logic                    rsp_timeout_r, rsp_timeout_s;
  logic [ADDR_WIDTH-1:0]   addr_r, addr_s;
  logic [DATA_WIDTH-1:0]   wdata_r, wdata_s;
  logic [STRB_WIDTH-1:0]   wstrb_r, wstrb_s;
  logic                    abort_s;

  logic aw_hs_s, w_hs_s, b_hs_s, ar_hs_s, r_hs_s, timeout_hit_s;
  assign aw_hs_s = awvalid_r & m_axi_awready;
  assign w_hs_s  = wvalid_r & m_axi_wready;
  assign b_hs_s  = bready_r & m_axi_bvalid;
  assign ar_hs_s = arvalid_r & m_axi_arready;
  assign r_hs_s  = rready_r & m_axi_rvalid;
  // A handshake on the same edge as the last timeout count still counts as completion.
  assign timeout_hit_s = TIMEOUT_EN && (cnt_r == CNT_LAST);

  // Next-state and next-output logic for the transaction sequencer.
  always_comb begin
    state_s       = state_r;
    cnt_s         = cnt_r;
    cmd_ready_s   = cmd_ready_r;
    awvalid_s     = awvalid_r;
    wvalid_s      = wvalid_r;
    bready_s      = bready_r;
    arvalid_s     = arvalid_r;
    rready_s      = rready_r;
    rsp_valid_s   = rsp_valid_r;
    rsp_write_s   = rsp_write_r;
    rsp_rdata_s   = rsp_rdata_r;
    rsp_resp_s    = rsp_resp_r;
    rsp_timeout_s = rsp_timeout_r;
    addr_s        = addr_r;
    wdata_s       = wdata_r;
    wstrb_s       = wstrb_r;
    abort_s       = 1'b0;
    case (state_r)
      IDLE: begin
        cnt_s = CNT_ZERO;
        if (cmd_valid && cmd_ready_r) begin
          cmd_ready_s = 1'b0;
          addr_s      = cmd_addr;
          wdata_s     = cmd_wdata;
          wstrb_s     = cmd_wstrb;
          rsp_write_s = cmd_write;
          if (cmd_write) begin
            state_s   = WR_AW_W;
            awvalid_s = 1'b1;
            wvalid_s  = 1'b1;
          end else begin
            state_s   = RD_AR;
            arvalid_s = 1'b1;
          end
        end else begin
          cmd_ready_s = 1'b1;
        end
      end
      WR_AW_W: begin
        awvalid_s = awvalid_r & ~aw_hs_s;
        wvalid_s  = wvalid_r & ~w_hs_s;
        if (!awvalid_s && !wvalid_s) begin
          state_s  = WR_B;
          bready_s = 1'b1;
          cnt_s    = CNT_ZERO;
        end else if (timeout_hit_s) begin
          abort_s = 1'b1;
        end else if (aw_hs_s || w_hs_s) begin
          cnt_s = CNT_ZERO;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      WR_B: begin
        if (b_hs_s) begin
          state_s       = RSP;
          bready_s      = 1'b0;
          rsp_valid_s   = 1'b1;
          rsp_resp_s    = m_axi_bresp;
          rsp_rdata_s   = {DATA_WIDTH{1'b0}};
          rsp_timeout_s = 1'b0;
          cnt_s         = CNT_ZERO;
        end else if (timeout_hit_s) begin
          abort_s = 1'b1;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      RD_AR: begin
        if (ar_hs_s) begin
          state_s   = RD_R;
          arvalid_s = 1'b0;
          rready_s  = 1'b1;
          cnt_s     = CNT_ZERO;
        end else if (timeout_hit_s) begin
          abort_s = 1'b1;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      RD_R: begin
        if (r_hs_s) begin
          state_s       = RSP;
          rready_s      = 1'b0;
          rsp_valid_s   = 1'b1;
          rsp_resp_s    = m_axi_rresp;
          rsp_rdata_s   = m_axi_rdata;
          rsp_timeout_s = 1'b0;
          cnt_s         = CNT_ZERO;
        end else if (timeout_hit_s) begin
          abort_s = 1'b1;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      RSP: begin
        cnt_s = CNT_ZERO;
        if (rsp_valid_r && rsp_ready) begin
          state_s     = IDLE;
          rsp_valid_s = 1'b0;
          cmd_ready_s = 1'b1;
        end else begin
          rsp_valid_s = 1'b1;
        end
      end
      default: begin
        state_s     = IDLE;
        cnt_s       = CNT_ZERO;
        cmd_ready_s = 1'b0;
        awvalid_s   = 1'b0;
        wvalid_s    = 1'b0;
        bready_s    = 1'b0;
        arvalid_s   = 1'b0;
        rready_s    = 1'b0;
        rsp_valid_s = 1'b0;
      end
    endcase
    // Abandon the hung transaction: drop every AXI valid/ready and report a synthetic SLVERR.
    if (abort_s) begin
      state_s       = RSP;
      cnt_s         = CNT_ZERO;
      awvalid_s     = 1'b0;
      wvalid_s      = 1'b0;
      bready_s      = 1'b0;
      arvalid_s     = 1'b0;
      rready_s      = 1'b0;
      rsp_valid_s   = 1'b1;
      rsp_resp_s    = 2'b10;
      rsp_timeout_s = 1'b1;
      rsp_rdata_s   = {DATA_WIDTH{1'b0}};
    end else begin
      rsp_timeout_s = rsp_timeout_s;
    end
  end

  // FSM state register.
  always_ff @(posedge m_axi_aclk or posedge m_axi_areset) begin
    if (m_axi_areset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Timeout counter and all registered outputs.
  always_ff @(posedge m_axi_aclk or posedge m_axi_areset) begin
    if (m_axi_areset) begin
      cnt_r         <= CNT_ZERO;
      cmd_ready_r   <= 1'b0;
      awvalid_r     <= 1'b0;
      wvalid_r      <= 1'b0;
      bready_r      <= 1'b0;
      arvalid_r     <= 1'b0;
      rready_r      <= 1'b0;
      rsp_valid_r   <= 1'b0;
      rsp_write_r   <= 1'b0;
      rsp_rdata_r   <= {DATA_WIDTH{1'b0}};
      rsp_resp_r    <= 2'b00;
      rsp_timeout_r <= 1'b0;
      addr_r        <= {ADDR_WIDTH{1'b0}};
      wdata_r       <= {DATA_WIDTH{1'b0}};
      wstrb_r       <= {STRB_WIDTH{1'b0}};
    end else begin
      cnt_r         <= cnt_s;
      cmd_ready_r   <= cmd_ready_s;
      awvalid_r     <= awvalid_s;
      wvalid_r      <= wvalid_s;
      bready_r      <= bready_s;
      arvalid_r     <= arvalid_s;
      rready_r      <= rready_s;
      rsp_valid_r   <= rsp_valid_s;
      rsp_write_r   <= rsp_write_s;
      rsp_rdata_r   <= rsp_rdata_s;
      rsp_resp_r    <= rsp_resp_s;
      rsp_timeout_r <= rsp_timeout_s;
      addr_r        <= addr_s;
      wdata_r       <= wdata_s;
      wstrb_r       <= wstrb_s;
    end
  end

  assign cmd_ready     = cmd_ready_r;
  assign rsp_valid     = rsp_valid_r;
  assign rsp_write     = rsp_write_r;
  assign rsp_rdata     = rsp_rdata_r;
  assign rsp_resp      = rsp_resp_r;
  assign rsp_timeout   = rsp_timeout_r;
  assign m_axi_awaddr  = addr_r;
  assign m_axi_awvalid = awvalid_r;
  assign m_axi_wdata   = wdata_r;
  assign m_axi_wstrb   = wstrb_r;
  assign m_axi_wvalid  = wvalid_r;
  assign m_axi_bready  = bready_r;
  assign m_axi_araddr  = addr_r;
  assign m_axi_arvalid = arvalid_r;
  assign m_axi_rready  = rready_r;

endmodule

// File: tb/tb_axi4lite_master.sv
// Bench for axi4lite_master: directed and randomized transactions against a cycle-scheduled
// slave and a register-file reference model, with timeout and asynchronous-reset scenarios.
module tb_axi4lite_master;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [8:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_write, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [8:0]  m_axi_awaddr, m_axi_araddr;
  logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic [31:0] m_axi_wdata, m_axi_rdata;
  logic [3:0]  m_axi_wstrb;
  logic [1:0]  m_axi_bresp, m_axi_rresp;
  logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic        m_axi_rvalid, m_axi_rready;

  int checks = 0;
  int errors = 0;
  logic [31:0] ref_mem   [0:127];
  logic [31:0] slave_mem [0:127];

  axi4lite_master #(.ADDR_WIDTH(9), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
    .m_axi_aclk(clk), .m_axi_areset(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready), .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic slave_idle();
    m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_arready = 1'b0;
    m_axi_bvalid = 1'b0; m_axi_rvalid = 1'b0; m_axi_bresp = 2'b00; m_axi_rresp = 2'b00;
    m_axi_rdata = 32'h0; rsp_ready = 1'b0;
  endtask

  // One command with a scheduled slave: aw_d/w_d/ar_d = wait cycles before the ready,
  // b_d/r_d = wait cycles before the response, hold = cycles rsp_ready stays low.
  task automatic run_txn(input logic wr, input logic [8:0] addr, input logic [31:0] wd,
                         input logic [3:0] ws, input int aw_d, input int w_d, input int b_d,
                         input int ar_d, input int r_d, input logic [1:0] resp, input int hold);
    int mx, k_rsp;
    logic tmo, accepted, b_done, r_done, rsp_done;
    logic [31:0] exp_rd, wd_cap;
    logic [1:0]  exp_resp;
    logic [8:0]  aw_cap, ar_cap;
    logic [3:0]  ws_cap;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = ws;
    accepted = 1'b0;
    for (int i = 0; i < 20 && !accepted; i++) begin
      accepted = cmd_ready;
      step();
    end
    cmd_valid = 1'b0;
    chk("cmd_accept", 64'(accepted), 64'd1);
    if (!accepted) return;
    mx    = (aw_d > w_d) ? aw_d : w_d;
    tmo   = !wr && (ar_d + 1 > TO);
    k_rsp = wr ? (2 + mx + b_d) : (tmo ? TO : (2 + ar_d + r_d));
    exp_resp = tmo ? 2'b10 : resp;
    exp_rd   = (wr || tmo) ? 32'h0 : ref_mem[addr[8:2]];
    if (wr) begin
      for (int b = 0; b < 4; b++) if (ws[b]) ref_mem[addr[8:2]][8*b +: 8] = wd[8*b +: 8];
    end
    b_done = 1'b0; r_done = 1'b0; rsp_done = 1'b0;
    aw_cap = 9'h0; ar_cap = 9'h0; wd_cap = 32'h0; ws_cap = 4'h0;
    for (int k = 0; k < 80; k++) begin
      if (rsp_done) begin
        chk("rsp_valid_drop", 64'(rsp_valid), 64'd0);
        chk("cmd_ready_back", 64'(cmd_ready), 64'd1);
        break;
      end
      chk("awvalid", 64'(m_axi_awvalid), 64'(wr && k <= aw_d));
      chk("wvalid", 64'(m_axi_wvalid), 64'(wr && k <= w_d));
      chk("bready", 64'(m_axi_bready), 64'(wr && k >= 1 + mx && k <= 1 + mx + b_d));
      chk("arvalid", 64'(m_axi_arvalid), 64'(!wr && k <= (tmo ? TO - 1 : ar_d)));
      chk("rready", 64'(m_axi_rready), 64'(!wr && !tmo && k >= 1 + ar_d && k <= 1 + ar_d + r_d));
      chk("rsp_valid", 64'(rsp_valid), 64'(k >= k_rsp));
      chk("cmd_ready_busy", 64'(cmd_ready), 64'd0);
      if (m_axi_awvalid) chk("awaddr", 64'(m_axi_awaddr), 64'(addr));
      if (m_axi_wvalid) chk("wdata_wstrb", {28'h0, m_axi_wstrb, m_axi_wdata}, {28'h0, ws, wd});
      if (m_axi_arvalid) chk("araddr", 64'(m_axi_araddr), 64'(addr));
      if (rsp_valid) begin
        chk("rsp_write", 64'(rsp_write), 64'(wr));
        chk("rsp_rdata", 64'(rsp_rdata), 64'(exp_rd));
        chk("rsp_resp", 64'(rsp_resp), 64'(exp_resp));
        chk("rsp_timeout", 64'(rsp_timeout), 64'(tmo));
      end
      // slave and consumer decisions for the next edge
      m_axi_awready = (k >= aw_d);
      m_axi_wready  = (k >= w_d);
      m_axi_arready = (k >= ar_d);
      if (m_axi_awvalid && m_axi_awready) aw_cap = m_axi_awaddr;
      if (m_axi_wvalid && m_axi_wready) begin wd_cap = m_axi_wdata; ws_cap = m_axi_wstrb; end
      if (m_axi_arvalid && m_axi_arready) ar_cap = m_axi_araddr;
      m_axi_bresp  = resp;
      m_axi_bvalid = wr && !b_done && (k + 1 >= 2 + mx + b_d);
      if (m_axi_bvalid && m_axi_bready) begin
        b_done = 1'b1;
        for (int b = 0; b < 4; b++) if (ws_cap[b]) slave_mem[aw_cap[8:2]][8*b +: 8] = wd_cap[8*b +: 8];
      end
      m_axi_rresp  = resp;
      m_axi_rdata  = slave_mem[ar_cap[8:2]];
      m_axi_rvalid = !wr && !tmo && !r_done && (k + 1 >= 2 + ar_d + r_d);
      if (m_axi_rvalid && m_axi_rready) r_done = 1'b1;
      rsp_ready = (k >= k_rsp + hold);
      rsp_done  = rsp_ready && rsp_valid;
      step();
    end
    chk("txn_complete", 64'(rsp_done), 64'd1);
    slave_idle();
  endtask

  initial begin
    logic [31:0] v;
    logic seen;
    for (int i = 0; i < 128; i++) begin
      v = $urandom;
      ref_mem[i] = v;
      slave_mem[i] = v;
    end
    ref_mem[7'h41] = 32'h1234_5678;
    slave_mem[7'h41] = 32'h1234_5678;
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 9'h0; cmd_wdata = 32'h0; cmd_wstrb = 4'h0;
    slave_idle();
    step(); step();
    chk("reset_ctrl", 64'({cmd_ready, m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid,
                          m_axi_rready, rsp_valid, rsp_timeout, rsp_write, rsp_resp}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("cmd_ready_after_reset", 64'(cmd_ready), 64'd1);

    // zero-wait write, delayed awready, reads with waits / error / stalled consumer, timeout
    run_txn(1'b1, 9'h100, 32'hA5A5_A5A5, 4'hF, 0, 0, 0, 0, 0, 2'b00, 0);
    run_txn(1'b1, 9'h10C, 32'h0BAD_F00D, 4'b0101, 3, 0, 0, 0, 0, 2'b00, 0);
    run_txn(1'b0, 9'h104, 32'h0, 4'h0, 0, 0, 0, 0, 2, 2'b00, 0);
    run_txn(1'b0, 9'h100, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'b10, 4);
    run_txn(1'b0, 9'h10C, 32'h0, 4'h0, 0, 0, 0, 1, 1, 2'b11, 1);
    run_txn(1'b0, 9'h110, 32'h0, 4'h0, 0, 0, 0, 255, 0, 2'b00, 0);

    // stray slave responses while idle must be ignored
    m_axi_bvalid = 1'b1; m_axi_rvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stray_ignored", 64'({m_axi_bready, m_axi_rready, rsp_valid, cmd_ready}), 64'b0001);
    end
    slave_idle();

    // asynchronous reset while waiting for B
    m_axi_awready = 1'b1; m_axi_wready = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 9'h108; cmd_wdata = 32'hDEAD_BEEF; cmd_wstrb = 4'hF;
    step();
    cmd_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step();
      seen = m_axi_bready;
    end
    chk("reach_wr_b", 64'(seen), 64'd1);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_ctrl", 64'({cmd_ready, m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid,
                              m_axi_rready, rsp_valid, rsp_timeout, rsp_write, rsp_resp}), 64'd0);
    chk("async_rst_data", {rsp_rdata, m_axi_wdata}, 64'd0);
    chk("async_rst_addr", 64'({m_axi_awaddr, m_axi_araddr, m_axi_wstrb}), 64'd0);
    slave_idle();
    step(); step();
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("cmd_ready_after_async_rst", 64'(cmd_ready), 64'd1);
    step();
    chk("no_rsp_after_rst", 64'(rsp_valid), 64'd0);
    run_txn(1'b0, 9'h104, 32'h0, 4'h0, 0, 0, 0, 1, 0, 2'b00, 0);

    // randomized traffic over a small register window
    for (int n = 0; n < 24; n++) begin
      run_txn(1'($urandom_range(0, 1)), {2'b10, 3'($urandom_range(0, 7)), 4'h0} | 9'(4 * $urandom_range(0, 3)),
              $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
              2'($urandom_range(0, 3)), $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
